// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit feeder: sequencer states and byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO; push visible to pop one cycle later, no bypass.
// Push while full and pop while empty are ignored; full/empty/level are registered.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];

    // Pointers are exactly PTR_W bits so they wrap at DEPTH without extra logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus sequencer driving a UART's transmit/tx_data/tx_done handshake.
// Write-to-transmit latency is 2 cycles when idle; writes while full are dropped and flagged.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [UART_DATA_W-1:0]   wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     uart_transmit,
    output logic [UART_DATA_W-1:0]   uart_tx_data,
    input  logic                     uart_tx_done,
    output logic                     busy,
    input  logic                     clr_err,
    output logic                     overflow,
    output logic                     ack_timeout
);
    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   transmit_q, transmit_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   overflow_q, overflow_d;
    logic                   ack_to_q, ack_to_d;
    logic                   ack_evt;
    logic                   fifo_pop;
    logic [UART_DATA_W-1:0] fifo_dat;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_dat (wr_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        transmit_d = transmit_q;
        tx_data_d  = tx_data_q;
        fifo_pop   = 1'b0;
        ack_evt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && uart_tx_done) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_dat;
                    transmit_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (!uart_tx_done) begin
                    transmit_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end else if (cnt_q == ACK_LAST) begin
                    // UART never took the frame: give up on this byte.
                    transmit_d = 1'b0;
                    ack_evt    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (uart_tx_done) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                transmit_d = 1'b0;
            end
        endcase
        // An error in the same cycle as clr_err must remain visible.
        overflow_d = (wr_en && full) || (overflow_q && !clr_err);
        ack_to_d   = ack_evt || (ack_to_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            transmit_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            ack_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            transmit_q <= transmit_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            ack_to_q   <= ack_to_d;
        end
    end

    assign uart_transmit = transmit_q;
    assign uart_tx_data  = tx_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign overflow      = overflow_q;
    assign ack_timeout   = ack_to_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench: UART responder model, per-cycle reference model, directed and random phases.
module tb_uart_tx_feeder;
    localparam int DEPTH       = 16;
    localparam int ACK_TIMEOUT = 64;
    localparam int GAP_CYCLES  = 0;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_err = 1'b0;
    logic          uart_tx_done = 1'b1;
    logic          full, empty, uart_transmit, busy, overflow, ack_timeout;
    logic [7:0]    uart_tx_data;
    logic [LW-1:0] level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .GAP_CYCLES  (GAP_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .uart_transmit (uart_transmit),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_done  (uart_tx_done),
        .busy          (busy),
        .clr_err       (clr_err),
        .overflow      (overflow),
        .ack_timeout   (ack_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue contents plus the frame-issue rules, advanced on each edge.
    localparam int PH_IDLE = 0, PH_ASK = 1, PH_SEND = 2, PH_GAP = 3;
    logic [7:0] m_q[$];
    int         m_phase = PH_IDLE;
    int         m_cnt   = 0;
    bit         m_tx = 0, m_ovf = 0, m_to = 0, started = 0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk) begin : model
        bit was_empty, was_full;
        if (rst) begin
            m_q.delete();
            m_phase = PH_IDLE; m_cnt = 0; m_tx = 0; m_ovf = 0; m_to = 0; m_data = 8'h00;
            started = 1;
        end else begin
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() == DEPTH);
            if (clr_err) begin m_ovf = 0; m_to = 0; end
            if (m_phase == PH_IDLE) begin
                if (!was_empty && uart_tx_done) begin
                    m_data = m_q.pop_front(); m_tx = 1; m_phase = PH_ASK; m_cnt = 0;
                end
            end else if (m_phase == PH_ASK) begin
                if (!uart_tx_done) begin m_tx = 0; m_phase = PH_SEND; end
                else if (m_cnt == ACK_TIMEOUT - 1) begin m_tx = 0; m_to = 1; m_phase = PH_IDLE; end
                else m_cnt++;
            end else if (m_phase == PH_SEND) begin
                if (uart_tx_done) begin m_phase = (GAP_CYCLES > 0) ? PH_GAP : PH_IDLE; m_cnt = 0; end
            end else begin
                if (m_cnt >= GAP_CYCLES - 1) m_phase = PH_IDLE; else m_cnt++;
            end
            if (wr_en) begin
                if (was_full) m_ovf = 1; else m_q.push_back(wr_data);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("transmit", uart_transmit, m_tx);
            chk("tx_data", uart_tx_data, m_data);
            chk("busy", busy, m_phase != PH_IDLE);
            chk("level", level, m_q.size());
            chk("full", full, m_q.size() == DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("overflow", overflow, m_ovf);
            chk("ack_timeout", ack_timeout, m_to);
        end
    end

    // Transmit pulse and high-run monitor.
    int pulses = 0, run = 0, last_run = 0;
    bit prev_tx = 0;
    always @(negedge clk) begin
        if (uart_transmit === 1'b1) begin
            if (!prev_tx) pulses++;
            run++;
        end else if (prev_tx) begin
            last_run = run;
            run = 0;
        end
        prev_tx = (uart_transmit === 1'b1);
    end

    // UART responder: 0 = normal, 1 = ignores transmit (done high), 2 = stuck busy (done low).
    int u_mode = 0, u_ack_lat = 0, u_frame = 4, u_busy = 0, u_wait = 0;
    logic [7:0] u_seen[$];
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (u_mode == 1) begin
                uart_tx_done = 1'b1; u_busy = 0; u_wait = 0;
            end else if (u_mode == 2) begin
                uart_tx_done = 1'b0; u_busy = 0; u_wait = 0;
            end else if (u_busy > 0) begin
                u_busy--;
                if (u_busy == 0) uart_tx_done = 1'b1;
            end else if (uart_transmit && uart_tx_done) begin
                if (u_wait < u_ack_lat) u_wait++;
                else begin
                    uart_tx_done = 1'b0; u_busy = u_frame; u_wait = 0;
                    u_seen.push_back(uart_tx_data);
                end
            end else begin
                uart_tx_done = 1'b1; u_wait = 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_en = 1'b0; clr_err = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = !busy && empty && uart_tx_done && (u_busy == 0);
        end
        chk(name, ok, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nff;
        bit ok;
        // Single byte
        u_mode = 0; u_ack_lat = 0; u_frame = 5;
        do_reset();
        chk("rst level", level, 0);
        chk("rst empty", empty, 1);
        chk("rst transmit", uart_transmit, 0);
        chk("rst tx_data", uart_tx_data, 8'h00);
        chk("rst busy", busy, 0);
        u_seen.delete();
        wr(8'hA5);
        tick();
        chk("single transmit", uart_transmit, 1);
        chk("single data", uart_tx_data, 8'hA5);
        tick();
        chk("single drop", uart_transmit, 0);
        chk("single busy", busy, 1);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            ok = !busy;
        end
        chk("single idle reached", ok, 1);
        chk("single done high", uart_tx_done, 1);
        chk("single level", level, 0);
        chk("single seen", u_seen.size() > 0 ? u_seen[0] : 32'hDEAD, 8'hA5);

        // Burst and order
        do_reset();
        u_seen.delete(); pulses = 0; u_mode = 2; u_frame = 20;
        tick();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        chk("burst full", full, 1);
        chk("burst no ovf", overflow, 0);
        chk("burst level", level, 16);
        u_mode = 0;
        drain("burst drain", 16 * 26 + 50);
        chk("burst pulses", pulses, 16);
        chk("burst count", u_seen.size(), 16);
        for (int i = 0; i < 16 && i < u_seen.size(); i++) chk("burst order", u_seen[i], i + 1);

        // Overflow
        do_reset();
        u_seen.delete(); u_mode = 2; u_frame = 3;
        tick();
        for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 254)));
        wr(8'hFF);
        chk("ovf flag", overflow, 1);
        chk("ovf level", level, 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf cleared", overflow, 0);
        u_mode = 0;
        drain("ovf drain", 16 * 10 + 50);
        chk("ovf sent count", u_seen.size(), 16);
        nff = 0;
        foreach (u_seen[i]) if (u_seen[i] == 8'hFF) nff++;
        chk("ovf FF never sent", nff, 0);

        // Ack timeout
        do_reset();
        u_seen.delete(); u_mode = 1; last_run = 0;
        wr(8'h3C);
        wr(8'h5A);
        ok = 0;
        for (int i = 0; i < 120 && !ok; i++) begin
            tick();
            ok = (last_run != 0);
        end
        chk("to transmit fell", ok, 1);
        chk("to run length", last_run, 64);
        chk("to flag", ack_timeout, 1);
        ok = 0;
        for (int i = 0; i < 5 && !ok; i++) begin
            tick();
            ok = uart_transmit;
        end
        chk("to retry next", ok, 1);
        chk("to next data", uart_tx_data, 8'h5A);
        u_mode = 0;
        drain("to drain", 100);
        chk("to seen count", u_seen.size(), 1);
        chk("to seen byte", u_seen.size() > 0 ? u_seen[0] : 32'hDEAD, 8'h5A);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to cleared", ack_timeout, 0);

        // Simultaneous push and pop at level 1
        do_reset();
        u_seen.delete(); u_mode = 2; u_frame = 4;
        tick();
        wr(8'hB1);
        chk("pp level before", level, 1);
        u_mode = 0;
        wr(8'hB2);
        chk("pp level kept", level, 1);
        chk("pp popped first", uart_tx_data, 8'hB1);
        drain("pp drain", 60);
        chk("pp count", u_seen.size(), 2);
        if (u_seen.size() == 2) begin
            chk("pp first", u_seen[0], 8'hB1);
            chk("pp second", u_seen[1], 8'hB2);
        end

        // Reset mid-frame
        do_reset();
        u_mode = 0; u_frame = 20; u_ack_lat = 1;
        wr(8'h11);
        wr(8'h22);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = busy && !uart_transmit && !uart_tx_done;
        end
        chk("mid reached wait_done", ok, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid transmit", uart_transmit, 0);
        chk("mid data", uart_tx_data, 8'h00);
        chk("mid busy", busy, 0);
        chk("mid level", level, 0);
        chk("mid empty", empty, 1);
        nff = pulses;
        tick(60);
        chk("mid no transmit", pulses, nff);

        // Randomised traffic
        u_ack_lat = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                int r;
                r = $urandom_range(0, 9);
                u_mode    = (r < 7) ? 0 : ((r < 9) ? 2 : 1);
                u_ack_lat = $urandom_range(0, 3);
                u_frame   = $urandom_range(1, 12);
            end
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 63) == 0);
            rst     = ($urandom_range(0, 999) == 0);
            tick();
        end
        wr_en = 1'b0; clr_err = 1'b0; rst = 1'b0; u_mode = 0;
        drain("random drain", DEPTH * 20 + 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
